mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single unified memory port (m_*) between the instruction-fetch requester (i*) and the MEM-stage load/store requester (d*).
- Sequences each transaction through a small FSM and returns a completion pulse plus a registered read word.
- Generates keep_if / keep_mem stall signals for the pipeline registers.
- Data side has priority; a starvation counter guarantees forward progress for fetch.

Parameters:
STARVE_LIMIT, 4, consecutive data grants allowed while ireq waits before fetch is forced
CNT_W, 3, width of starvation counter (must hold STARVE_LIMIT)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
ireq  in  1  fetch request; held until keep_if falls
iaddr  in  32  fetch address (always word read)
irdata  out  32  fetched word, registered
iready_n  out  1  active-low one-cycle fetch completion pulse
dreq  in  1  data request; held until keep_mem falls
dwrite  in  1  1 = store, 0 = load
daddr  in  32  data address
dsize  in  2  access size code (pass-through)
dwdata  in  32  store data
drdata  out  32  raw load word, registered (sign/zero extension is done by MEM stage)
dready_n  out  1  active-low one-cycle data completion pulse
m_req  out  1  memory request
m_write  out  1  memory write enable
m_addr  out  32  memory address
m_size  out  2  memory access size
m_wdata  out  32  memory write data
m_rdata  in  32  memory read data
m_ready_n  in  1  active-low memory completion
m_busy  in  1  memory cannot accept a new request
keep_if  out  1  hold IF/PC registers
keep_mem  out  1  hold MEM-stage and upstream registers

Behaviour:
- FSM states: IDLE, BUSY_I, BUSY_D, DONE. sel register records the owner of the last grant.
- Reset values: state=IDLE, starve_cnt=0, m_req=0, m_write=0, m_addr=0, m_size=0, m_wdata=0, irdata=0, drdata=0, iready_n=1, dready_n=1. Reset mid-transaction aborts the transaction silently; no completion pulse is produced.
- IDLE: when m_busy=1, no grant.
  - Otherwise, dreq and not (ireq and starve_cnt==STARVE_LIMIT) -> BUSY_D.
  - Otherwise, ireq -> BUSY_I.
  - On grant, capture into m_* registers: addr, size, write, and wdata. wdata is captured only for stores; loads take 0. Fetch grants use m_size=2'b10 and m_write=0.
- BUSY_x: m_req=1 and the m_* registers are held stable. Remain in the state while m_ready_n=1. m_busy is ignored once granted.
  - When m_ready_n=0: latch m_rdata into irdata (BUSY_I) or into drdata (BUSY_D loads only; stores leave drdata unchanged). Clear m_req and go to DONE.
- DONE: lasts one cycle. The owner's ready_n=0 and the state returns to IDLE. No grant is made in DONE, so stale held requests are never re-issued.
- keep_if = ireq and not (DONE and sel==I); keep_mem = dreq and not (DONE and sel==D). Both are combinational.
- Minimum latency: request seen in cycle 0 -> BUSY in cycle 1 -> m_ready_n=0 in cycle 1 -> DONE/pulse in cycle 2, where keep falls. Total: 3 cycles per access.
- starve_cnt:
  - Increments, saturating at STARVE_LIMIT, on each D grant made while ireq=1.
  - Clears on each I grant.
  - Clears when ireq=0 in IDLE.
- Simultaneous ireq and dreq with cnt<LIMIT: D is granted, and I waits with keep_if=1.
- The i* / d* inputs are sampled only in IDLE; changes during BUSY have no effect.

Decomposition:
- Shared package (define.v): state encodings (IDLE=2'd0, BUSY_I=2'd1, BUSY_D=2'd2, DONE=2'd3), SIZE_WORD=2'b10, and SEL_I/SEL_D constants.
- One natural sub-module, arb_starve_counter: saturating counter with inc/clr/at_limit.
- The FSM and the m_* register bank stay in the top module.

Test Plan:
- Single fetch: ireq=1, iaddr=0x100, m_ready_n low in cycle 1 with m_rdata=0x00000013 -> m_req=1 in cycle 1 only, iready_n=0 and irdata=0x13 in cycle 2, keep_if 1,1,0.
- Store: dreq=1, dwrite=1, daddr=0x2000, dwdata=0xDEADBEEF, dsize=2 -> m_write=1, m_wdata=0xDEADBEEF, m_addr=0x2000 held through 3 wait cycles; dready_n pulses once; drdata unchanged.
- Contention: ireq and dreq both high in cycle 0 -> BUSY_D first; fetch is granted on the first IDLE after DONE, and keep_if stays 1 throughout.
- Starvation: ireq held, 5 back-to-back loads -> 4 data grants, then a forced fetch grant; starve_cnt returns to 0.
- m_busy=1 for 3 cycles with dreq pending -> no m_req during those cycles; grant occurs on the first cycle with m_busy=0.
- Reset asserted in BUSY_D -> all outputs return to reset values immediately; no dready_n pulse; after release, a held dreq is re-granted from IDLE.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified memory port arbiter.
package mem_port_arbiter_pkg;

  // Transaction sequencer states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

  // Owner of the most recent grant
  typedef enum logic {
    SEL_I = 1'b0,
    SEL_D = 1'b1
  } arb_sel_t;

  // Access size code for a full 32-bit word (instruction fetches)
  localparam logic [1:0] SIZE_WORD = 2'b10;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester, pipeline-stall and memory-port signals of the arbiter.
// master: the arbiter itself (drives the memory port and completions).
// slave:  the surrounding pipeline and memory (drive requests and responses).
interface mem_port_arbiter_if;

  // Instruction-fetch requester
  logic        ireq;
  logic [31:0] iaddr;
  logic [31:0] irdata;
  logic        iready_n;

  // MEM-stage load/store requester
  logic        dreq;
  logic        dwrite;
  logic [31:0] daddr;
  logic [1:0]  dsize;
  logic [31:0] dwdata;
  logic [31:0] drdata;
  logic        dready_n;

  // Unified memory port
  logic        m_req;
  logic        m_write;
  logic [31:0] m_addr;
  logic [1:0]  m_size;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata;
  logic        m_ready_n;
  logic        m_busy;

  // Pipeline register holds
  logic        keep_if;
  logic        keep_mem;

  modport master (
    input  ireq, iaddr,
    output irdata, iready_n,
    input  dreq, dwrite, daddr, dsize, dwdata,
    output drdata, dready_n,
    output m_req, m_write, m_addr, m_size, m_wdata,
    input  m_rdata, m_ready_n, m_busy,
    output keep_if, keep_mem
  );

  modport slave (
    output ireq, iaddr,
    input  irdata, iready_n,
    output dreq, dwrite, daddr, dsize, dwdata,
    input  drdata, dready_n,
    input  m_req, m_write, m_addr, m_size, m_wdata,
    output m_rdata, m_ready_n, m_busy,
    input  keep_if, keep_mem
  );

endinterface

// File: rtl/mem_port_arbiter_starve_counter.sv
// Saturating counter of data grants made while a fetch is waiting.
module arb_starve_counter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned LIMIT = 4,
  parameter int unsigned W     = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         at_limit
);

  localparam logic [W-1:0] LIMIT_V = W'(LIMIT);

  // Clear wins over increment; increment stops at LIMIT
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != LIMIT_V)) begin
      cnt <= cnt + W'(1);
    end
  end

  assign at_limit = (cnt == LIMIT_V);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store requesters.
// Data side has priority; the starvation counter forces a fetch grant
// after STARVE_LIMIT consecutive data grants made while a fetch waits.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned CNT_W        = 3
) (
  input  logic                clk,
  input  logic                rst,
  mem_port_arbiter_if.master  bus
);

  arb_state_t       state;
  arb_state_t       state_nx;
  arb_sel_t         sel;

  logic             grant_i;
  logic             grant_d;
  logic             xfer_done;
  logic             starve_inc;
  logic             starve_clr;
  logic             starve_at_limit;
  logic [CNT_W-1:0] starve_cnt;

  arb_starve_counter #(
    .LIMIT (STARVE_LIMIT),
    .W     (CNT_W)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .inc      (starve_inc),
    .clr      (starve_clr),
    .cnt      (starve_cnt),
    .at_limit (starve_at_limit)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: begin
        if (grant_d) begin
          state_nx = BUSY_D;
        end else if (grant_i) begin
          state_nx = BUSY_I;
        end
      end
      BUSY_I,
      BUSY_D: begin
        if (!bus.m_ready_n) begin
          state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Grant decode, completion detect, stall outputs and counter controls
  always_comb begin
    grant_i = 1'b0;
    grant_d = 1'b0;
    if ((state == IDLE) && !bus.m_busy) begin
      if (bus.dreq && !(bus.ireq && starve_at_limit)) begin
        grant_d = 1'b1;
      end else if (bus.ireq) begin
        grant_i = 1'b1;
      end
    end
    xfer_done    = ((state == BUSY_I) || (state == BUSY_D)) && !bus.m_ready_n;
    bus.keep_if  = bus.ireq && !((state == DONE) && (sel == SEL_I));
    bus.keep_mem = bus.dreq && !((state == DONE) && (sel == SEL_D));
    starve_inc   = grant_d && bus.ireq;
    starve_clr   = grant_i || ((state == IDLE) && !bus.ireq);
  end

  // Memory-port register bank, read-data capture and completion pulses
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sel          <= SEL_I;
      bus.m_req    <= 1'b0;
      bus.m_write  <= 1'b0;
      bus.m_addr   <= '0;
      bus.m_size   <= '0;
      bus.m_wdata  <= '0;
      bus.irdata   <= '0;
      bus.drdata   <= '0;
      bus.iready_n <= 1'b1;
      bus.dready_n <= 1'b1;
    end else begin
      bus.iready_n <= 1'b1;
      bus.dready_n <= 1'b1;
      if (grant_d) begin
        sel         <= SEL_D;
        bus.m_req   <= 1'b1;
        bus.m_write <= bus.dwrite;
        bus.m_addr  <= bus.daddr;
        bus.m_size  <= bus.dsize;
        bus.m_wdata <= bus.dwrite ? bus.dwdata : '0;
      end else if (grant_i) begin
        sel         <= SEL_I;
        bus.m_req   <= 1'b1;
        bus.m_write <= 1'b0;
        bus.m_addr  <= bus.iaddr;
        bus.m_size  <= SIZE_WORD;
        bus.m_wdata <= '0;
      end
      // The completion pulse is registered so it lines up with DONE
      if (xfer_done) begin
        bus.m_req <= 1'b0;
        if (state == BUSY_I) begin
          bus.irdata   <= bus.m_rdata;
          bus.iready_n <= 1'b0;
        end else begin
          if (!bus.m_write) begin
            bus.drdata <= bus.m_rdata;
          end
          bus.dready_n <= 1'b0;
        end
      end
    end
  end

endmodule
